// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, FSM state type and request legality helper for the load/store unit
package lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Unused encodings, and unsigned variants on a store, have no memory meaning.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic store);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (f3[2] && store);
    endfunction

endpackage

// File: rtl/load_memory_decoder.sv
// rtl/load_memory_decoder.sv - selects and extends the addressed byte/halfword of a returned memory word
// ld_type  : funct3 of the load
// addr_lo  : byte offset within the word
// mem_word : raw word from memory (unaddressed lanes may hold anything)
// ld_data  : right-aligned, sign- or zero-extended result
module load_memory_decoder
    import lsu_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        // addr_lo[0] is deliberately ignored for halfwords
        half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

        case (ld_type)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            F3_W:    ld_data = mem_word;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/store_memory_encoder.sv
// rtl/store_memory_encoder.sv - byte-lane strobes and replicated write data for a store
// st_type : funct3 of the store
// addr_lo : byte offset within the word
// st_data : right-aligned store data
// wstrb   : byte lanes written
// wdata   : store data replicated across all lanes
module store_memory_encoder
    import lsu_pkg::*;
(
    input  logic [2:0]  st_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    always_comb begin
        case (st_type)
            F3_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            F3_W: begin
                wstrb = 4'b1111;
                wdata = st_data;
            end
            default: begin
                wstrb = 4'b0000;
                wdata = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32I load/store unit with timeout
// Optional feature macro: LSU_MISALIGN_CHECK_EN (reject misaligned H/HU/W accesses)
// clk, reset                        : clock, asynchronous active-high reset
// req_valid/ready/store/type/addr/wdata : core request handshake and payload
// resp_valid/rdata/error            : one-cycle completion pulse with load data or error
// mem_valid/ready/addr/we/wstrb/wdata   : word-aligned memory request
// mem_rvalid/rdata                  : memory load data return
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Timeout fires in the MAX_WAIT-th cycle spent in ISSUE+WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    lsu_state_e  state;
    logic        store_q;
    logic [2:0]  type_q;
    logic [1:0]  addr_lo_q;
    logic [7:0]  wait_cnt;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [3:0]  enc_wstrb;
    logic [31:0] enc_wdata;
    logic [31:0] ld_data;
    logic        misalign;
    logic        reject;
    logic        accept;
    logic        timeout;

    store_memory_encoder u_store_enc (
        .st_type (req_type),
        .addr_lo (req_addr[1:0]),
        .st_data (req_wdata),
        .wstrb   (enc_wstrb),
        .wdata   (enc_wdata)
    );

    load_memory_decoder u_load_dec (
        .ld_type  (type_q),
        .addr_lo  (addr_lo_q),
        .mem_word (mem_rdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if ((req_type == F3_H || req_type == F3_HU) && req_addr[0])
            misalign = 1'b1;
        if (req_type == F3_W && req_addr[1:0] != 2'b00)
            misalign = 1'b1;
`endif
    end

    assign reject  = f3_illegal(req_type, req_store) || misalign;
    assign accept  = req_valid && req_ready;
    assign timeout = (wait_cnt == WAIT_LAST);

    // resp_valid is registered from RESP, so it is seen in the cycle after
    // RESP, together with req_ready; this gives a 2-cycle error latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            store_q    <= 1'b0;
            type_q     <= 3'd0;
            addr_lo_q  <= 2'd0;
            wait_cnt   <= 8'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= 32'd0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'd0;
            mem_wdata  <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        store_q   <= req_store;
                        type_q    <= req_type;
                        addr_lo_q <= req_addr[1:0];
                        wait_cnt  <= 8'd0;
                        rdata_q   <= 32'd0;
                        if (reject) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else begin
                            err_q     <= 1'b0;
                            state     <= ST_ISSUE;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_we    <= req_store;
                            mem_wstrb <= req_store ? enc_wstrb : 4'd0;
                            mem_wdata <= req_store ? enc_wdata : 32'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (timeout || mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'd0;
                        mem_wdata <= 32'd0;
                        if (timeout) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else begin
                            state <= store_q ? ST_RESP : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (timeout) begin
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end else if (mem_rvalid) begin
                        rdata_q <= ld_data;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b1;
                    resp_error <= err_q;
                    resp_rdata <= err_q ? 32'd0 : rdata_q;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
